// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared states, nibble width and index sizing for the serial adder
package nibble_serial_adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int NIBBLE_W = 4;
   function automatic int idx_width(input int width);
      int nib;
      nib = width / NIBBLE_W;
      return (nib <= 1) ? 1 : $clog2(nib);
   endfunction
endpackage

// File: rtl/lookahead_adder_4bit.sv
// lookahead_adder_4bit: 4-bit carry-lookahead adder slice
module lookahead_adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] g, p;
   logic [4:0] c;
   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      sum  = p ^ c[3:0];
      cout = c[4];
   end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder reusing one 4-bit lookahead slice, one nibble per clock
import nibble_serial_adder_pkg::*;
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NIB = WIDTH / NIBBLE_W;
   localparam int IW  = idx_width(WIDTH);
   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [NIBBLE_W-1:0]  s_sum;
   logic                 s_cout;
   lookahead_adder_4bit u_slice (
      .a    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
      .b    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (state_q == RUN) begin
         sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_sum;
         carry_d = s_cout;
         idx_d   = idx_q + IW'(1);
         if (idx_q == IW'(NIB - 1)) begin
            cout_d  = s_cout;
            ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
            state_d = DONE;
         end
      end else if (start) begin
         // DONE accepts a new start directly so back-to-back operations skip IDLE
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         idx_d   = '0;
         state_d = RUN;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed table, corner sequences and random checks against an arithmetic model
module tb_nibble_serial_adder;
   localparam int W = 16;
   localparam int NIB = W / 4;
   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin_i = 1'b0;
   logic [W-1:0] a_i = '0, b_i = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;
   int           pass_n = 0, tot_n = 0;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a, b;
      logic         c;
      logic [W-1:0] s;
      logic         co, ov;
   } vec_t;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] s;
      logic       o;
      s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      return {o, s};
   endfunction

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         chk("busy_run", {{(W-1){1'b0}}, busy}, 1);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_res(input string nm, input logic [W-1:0] s, input logic co, input logic ov);
      chk({nm, "_done"}, {{(W-1){1'b0}}, done}, 1);
      chk({nm, "_sum"}, sum, s);
      chk({nm, "_cout"}, {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, co});
      chk({nm, "_ovf"}, {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, ov});
   endtask

   task automatic do_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W-1:0] s, input logic co, input logic ov);
      int n;
      @(negedge clk);
      a_i = x; b_i = y; cin_i = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk({nm, "_latency"}, W'(n), W'(NIB));
      check_res(nm, s, co, ov);
      @(negedge clk);
      chk({nm, "_idle_done"}, {{(W-1){1'b0}}, done}, 0);
      chk({nm, "_idle_busy"}, {{(W-1){1'b0}}, busy}, 0);
   endtask

   initial begin
      vec_t        tbl[5];
      logic [W+1:0] r;
      logic [W-1:0] ra[4], rb[4];
      logic         rc[4];
      int           n;
      tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      tbl[4] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};

      #1;
      chk("rst_busy", {{(W-1){1'b0}}, busy}, 0);
      chk("rst_done", {{(W-1){1'b0}}, done}, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", {{(W-1){1'b0}}, cout}, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++)
         do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, tbl[i].ov);

      // start during RUN must be ignored
      @(negedge clk);
      a_i = 16'h00FF; b_i = 16'h0000; cin_i = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a_i = 16'hABCD; b_i = 16'h1111; cin_i = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("ign_latency", W'(n), W'(2));
      check_res("ign", 16'h0100, 1'b0, 1'b0);
      @(negedge clk);
      chk("ign_no_restart", {{(W-1){1'b0}}, busy}, 0);

      // back-to-back with start held high
      for (int k = 0; k < 4; k++) begin
         ra[k] = W'($urandom); rb[k] = W'($urandom); rc[k] = 1'($urandom);
      end
      @(negedge clk);
      a_i = ra[0]; b_i = rb[0]; cin_i = rc[0]; start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         wait_done(n);
         chk($sformatf("b2b%0d_period", k), W'(n), W'(NIB));
         r = ref_add(ra[k], rb[k], rc[k]);
         check_res($sformatf("b2b%0d", k), r[W-1:0], r[W], r[W+1]);
         if (k < 3) begin
            a_i = ra[k+1]; b_i = rb[k+1]; cin_i = rc[k+1];
         end else start = 1'b0;
         @(negedge clk);
         if (k < 3) chk($sformatf("b2b%0d_nobubble", k), {{(W-1){1'b0}}, busy}, 1);
      end
      chk("b2b_end_busy", {{(W-1){1'b0}}, busy}, 0);

      for (int i = 0; i < 20; i++) begin
         ra[0] = W'($urandom); rb[0] = W'($urandom); rc[0] = 1'($urandom);
         r = ref_add(ra[0], rb[0], rc[0]);
         do_op($sformatf("rnd%0d", i), ra[0], rb[0], rc[0], r[W-1:0], r[W], r[W+1]);
      end

      do_op("pre_rst", 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0);
      do_op("pre_rst2", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
      @(negedge clk);
      a_i = 16'h4444; b_i = 16'h4444; cin_i = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {{(W-1){1'b0}}, busy}, 0);
      chk("arst_done", {{(W-1){1'b0}}, done}, 0);
      chk("arst_sum", sum, 0);
      chk("arst_cout", {{(W-1){1'b0}}, cout}, 0);
      chk("arst_ovf", {{(W-1){1'b0}}, ovf}, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op("post_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
